exception_ctrl_unit: RTL and testbench

//  Parametrised exception controller for the 5-stage pipeline: detects faults in ID/EXE/MEM,

---
 rtl/exc_pkg.sv | 41 ++++
 rtl/exc_detect.sv | 94 +++++++++
 rtl/exception_ctrl_unit.sv | 202 ++++++++++++++++++++
 tb/tb_exception_ctrl_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: cause codes, FSM states and stage encoding.

package exc_pkg;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_SP_OVF  = 3'd1;
    localparam logic [2:0] CAUSE_SP_UNF  = 3'd2;
    localparam logic [2:0] CAUSE_BAD_OPC = 3'd3;
    localparam logic [2:0] CAUSE_DIV0    = 3'd4;
    localparam logic [2:0] CAUSE_IMEM    = 3'd5;
    localparam logic [2:0] CAUSE_DMEM    = 3'd6;
    localparam logic [2:0] CAUSE_DOUBLE  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_VECTOR,
        ST_HANDLER,
        ST_HALT
    } exc_state_t;

    typedef enum logic [1:0] {
        STG_NONE,
        STG_ID,
        STG_EXE,
        STG_MEM
    } exc_stage_t;

    // Flush vector {mem, exe, id}: the faulting stage and everything younger than it.
    function automatic logic [2:0] flush_mask(exc_stage_t stage);
        logic [2:0] m;
        case (stage)
            STG_MEM: m = 3'b111;
            STG_EXE: m = 3'b011;
            STG_ID:  m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exc_detect.sv
// Combinational fault detection: qualifies each cause and picks the oldest faulting stage.

module exc_detect
    import exc_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int SP_LO    = 2047,
    parameter int SP_HI    = 4095,
    parameter int IMEM_MAX = 1048575,
    parameter int DMEM_MAX = 4095,
    parameter int OPC_MAX  = 10,
    parameter int DIV_OP   = 10
) (
    input  logic              valid_id,
    input  logic              valid_exe,
    input  logic              valid_mem,
    input  logic [3:0]        opcode_id,
    input  logic [3:0]        alu_op_exe,
    input  logic [DATA_W-1:0] rsrc_exe,
    input  logic              is_jmp_exe,
    input  logic [ADDR_W-1:0] jmp_addr_exe,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] addr_mem,
    input  logic [ADDR_W-1:0] sp_mem,
    input  logic [ADDR_W-1:0] pc_id,
    input  logic [ADDR_W-1:0] pc_exe,
    input  logic [ADDR_W-1:0] pc_mem,
    input  logic [5:0]        mask,
    output logic              hit,
    output logic [2:0]        cause,
    output exc_stage_t        stage,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] SP_LO_C    = ADDR_W'(SP_LO);
    localparam logic [ADDR_W-1:0] SP_HI_C    = ADDR_W'(SP_HI);
    localparam logic [ADDR_W-1:0] IMEM_MAX_C = ADDR_W'(IMEM_MAX);
    localparam logic [DATA_W-1:0] DMEM_MAX_C = DATA_W'(DMEM_MAX);
    localparam logic [3:0]        OPC_MAX_C  = 4'(OPC_MAX);
    localparam logic [3:0]        DIV_OP_C   = 4'(DIV_OP);

    logic [6:1] raw;
    logic [6:1] armed;

    always_comb begin
        raw                = '0;
        raw[CAUSE_SP_OVF]  = valid_mem && (sp_mem > SP_HI_C);
        raw[CAUSE_SP_UNF]  = valid_mem && (sp_mem < SP_LO_C);
        raw[CAUSE_BAD_OPC] = valid_id && (opcode_id > OPC_MAX_C);
        raw[CAUSE_DIV0]    = valid_exe && (alu_op_exe == DIV_OP_C) && (rsrc_exe == '0);
        raw[CAUSE_IMEM]    = valid_exe && is_jmp_exe && (jmp_addr_exe > IMEM_MAX_C);
        raw[CAUSE_DMEM]    = valid_mem && (mem_rd || mem_wr) && (addr_mem > DMEM_MAX_C);
        // Mask bit i-1 suppresses cause i.
        armed              = raw & ~mask;
    end

    // Oldest stage wins; within a stage the lower cause number wins except DMEM trails the SP checks.
    always_comb begin
        hit   = 1'b1;
        cause = CAUSE_NONE;
        stage = STG_NONE;
        pc    = '0;
        if (armed[CAUSE_SP_OVF]) begin
            cause = CAUSE_SP_OVF;
            stage = STG_MEM;
            pc    = pc_mem;
        end else if (armed[CAUSE_SP_UNF]) begin
            cause = CAUSE_SP_UNF;
            stage = STG_MEM;
            pc    = pc_mem;
        end else if (armed[CAUSE_DMEM]) begin
            cause = CAUSE_DMEM;
            stage = STG_MEM;
            pc    = pc_mem;
        end else if (armed[CAUSE_DIV0]) begin
            cause = CAUSE_DIV0;
            stage = STG_EXE;
            pc    = pc_exe;
        end else if (armed[CAUSE_IMEM]) begin
            cause = CAUSE_IMEM;
            stage = STG_EXE;
            pc    = pc_exe;
        end else if (armed[CAUSE_BAD_OPC]) begin
            cause = CAUSE_BAD_OPC;
            stage = STG_ID;
            pc    = pc_id;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exception_ctrl_unit.sv
// Exception controller top: flush/vector/handler FSM, EPC/CAUSE capture and taken-exception counter.

module exception_ctrl_unit
    import exc_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 16,
    parameter int          SP_LO        = 2047,
    parameter int          SP_HI        = 4095,
    parameter int          IMEM_MAX     = 1048575,
    parameter int          DMEM_MAX     = 4095,
    parameter int          OPC_MAX      = 10,
    parameter int          DIV_OP       = 10,
    parameter int          FLUSH_CYCLES = 3,
    parameter int unsigned VEC_BASE     = 32'h20,
    parameter int          VEC_STRIDE   = 4,
    parameter int          CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ID_in,
    input  logic              valid_EXE_in,
    input  logic              valid_MEM_in,
    input  logic [3:0]        opcode_ID_in,
    input  logic [3:0]        alu_op_EXE_in,
    input  logic [DATA_W-1:0] rsrc_EXE_in,
    input  logic              is_jmp_EXE_in,
    input  logic [ADDR_W-1:0] jmp_addr_EXE_in,
    input  logic              mem_rd_MEM_in,
    input  logic              mem_wr_MEM_in,
    input  logic [DATA_W-1:0] addr_MEM_in,
    input  logic [ADDR_W-1:0] sp_MEM_in,
    input  logic [ADDR_W-1:0] pc_ID_in,
    input  logic [ADDR_W-1:0] pc_EXE_in,
    input  logic [ADDR_W-1:0] pc_MEM_in,
    input  logic [5:0]        mask_in,
    input  logic              eret_in,
    output logic              flush_ID_out,
    output logic              flush_EXE_out,
    output logic              flush_MEM_out,
    output logic              stall_fetch_out,
    output logic              vector_valid_out,
    output logic [ADDR_W-1:0] vector_addr_out,
    output logic [ADDR_W-1:0] epc_out,
    output logic [2:0]        cause_out,
    output logic              in_handler_out,
    output logic              halted_out,
    output logic [CNT_W-1:0]  exc_count_out
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    exc_state_t        state;
    logic [FC_W-1:0]   flush_cnt;
    logic [ADDR_W-1:0] epc_r;
    logic [2:0]        cause_r;
    logic [CNT_W-1:0]  count_r;
    logic              vec_valid_r;
    logic [ADDR_W-1:0] vec_addr_r;
    logic              in_handler_r;
    logic              halted_r;

    logic              det_hit;
    logic [2:0]        det_cause;
    exc_stage_t        det_stage;
    logic [ADDR_W-1:0] det_pc;
    logic [ADDR_W-1:0] vec_target;
    logic [2:0]        flush_vec;
    logic              stall_r;

    exc_detect #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SP_LO    (SP_LO),
        .SP_HI    (SP_HI),
        .IMEM_MAX (IMEM_MAX),
        .DMEM_MAX (DMEM_MAX),
        .OPC_MAX  (OPC_MAX),
        .DIV_OP   (DIV_OP)
    ) u_detect (
        .valid_id     (valid_ID_in),
        .valid_exe    (valid_EXE_in),
        .valid_mem    (valid_MEM_in),
        .opcode_id    (opcode_ID_in),
        .alu_op_exe   (alu_op_EXE_in),
        .rsrc_exe     (rsrc_EXE_in),
        .is_jmp_exe   (is_jmp_EXE_in),
        .jmp_addr_exe (jmp_addr_EXE_in),
        .mem_rd       (mem_rd_MEM_in),
        .mem_wr       (mem_wr_MEM_in),
        .addr_mem     (addr_MEM_in),
        .sp_mem       (sp_MEM_in),
        .pc_id        (pc_ID_in),
        .pc_exe       (pc_EXE_in),
        .pc_mem       (pc_MEM_in),
        .mask         (mask_in),
        .hit          (det_hit),
        .cause        (det_cause),
        .stage        (det_stage),
        .pc           (det_pc)
    );

    assign vec_target = ADDR_W'(VEC_BASE) + ADDR_W'(cause_r) * ADDR_W'(VEC_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            flush_cnt    <= '0;
            epc_r        <= '0;
            cause_r      <= CAUSE_NONE;
            count_r      <= '0;
            vec_valid_r  <= 1'b0;
            vec_addr_r   <= '0;
            in_handler_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            vec_valid_r <= 1'b0;
            vec_addr_r  <= '0;
            case (state)
                ST_IDLE: begin
                    if (det_hit) begin
                        epc_r     <= det_pc;
                        cause_r   <= det_cause;
                        flush_cnt <= FLUSH_LAST;
                        state     <= ST_FLUSH;
                        if (count_r != {CNT_W{1'b1}}) begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state       <= ST_VECTOR;
                        vec_valid_r <= 1'b1;
                        vec_addr_r  <= vec_target;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                ST_VECTOR: begin
                    state        <= ST_HANDLER;
                    in_handler_r <= 1'b1;
                end
                // A fault inside the handler outranks a simultaneous ERET.
                ST_HANDLER: begin
                    if (det_hit) begin
                        state        <= ST_HALT;
                        in_handler_r <= 1'b0;
                        halted_r     <= 1'b1;
                        cause_r      <= CAUSE_DOUBLE;
                        epc_r        <= det_pc;
                    end else if (eret_in) begin
                        state        <= ST_IDLE;
                        in_handler_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    halted_r <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flushes in IDLE must act in the detection cycle, so that path stays combinational.
    always_comb begin
        flush_vec = 3'b000;
        stall_r   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (det_hit && !reset) begin
                    flush_vec = flush_mask(det_stage);
                    stall_r   = 1'b1;
                end
            end
            ST_FLUSH, ST_HALT: begin
                flush_vec = 3'b111;
                stall_r   = 1'b1;
            end
            default: begin
                flush_vec = 3'b000;
                stall_r   = 1'b0;
            end
        endcase
    end

    assign flush_MEM_out    = flush_vec[2];
    assign flush_EXE_out    = flush_vec[1];
    assign flush_ID_out     = flush_vec[0];
    assign stall_fetch_out  = stall_r;
    assign vector_valid_out = vec_valid_r;
    assign vector_addr_out  = vec_addr_r;
    assign epc_out          = epc_r;
    assign cause_out        = cause_r;
    assign in_handler_out   = in_handler_r;
    assign halted_out       = halted_r;
    assign exc_count_out    = count_r;

endmodule

// File: tb/tb_exception_ctrl_unit.sv
// Self-checking bench for exception_ctrl_unit: expected vectors queued at stimulus, compared on each vector pulse.

module tb_exception_ctrl_unit;

    localparam logic [31:0] VEC_BASE   = 32'h20;
    localparam int          VEC_STRIDE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ID_in, valid_EXE_in, valid_MEM_in;
    logic [3:0]  opcode_ID_in, alu_op_EXE_in;
    logic [15:0] rsrc_EXE_in;
    logic        is_jmp_EXE_in;
    logic [31:0] jmp_addr_EXE_in;
    logic        mem_rd_MEM_in, mem_wr_MEM_in;
    logic [15:0] addr_MEM_in;
    logic [31:0] sp_MEM_in, pc_ID_in, pc_EXE_in, pc_MEM_in;
    logic [5:0]  mask_in;
    logic        eret_in;
    logic        flush_ID_out, flush_EXE_out, flush_MEM_out, stall_fetch_out;
    logic        vector_valid_out;
    logic [31:0] vector_addr_out, epc_out;
    logic [2:0]  cause_out;
    logic        in_handler_out, halted_out;
    logic [7:0]  exc_count_out;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] epc;
        logic [31:0] vec;
    } exp_t;

    typedef struct {
        logic        v_id, v_exe, v_mem;
        logic [3:0]  opcode, alu_op;
        logic [15:0] rsrc;
        logic        is_jmp;
        logic [31:0] jmp_addr;
        logic        rd, wr;
        logic [15:0] addr_mem;
        logic [31:0] sp, pc_id, pc_exe, pc_mem;
        logic [5:0]  mask;
        logic        eret;
        logic [2:0]  exp_cause;
        logic [31:0] exp_epc;
        logic [2:0]  exp_flush;
    } stim_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    exception_ctrl_unit dut (
        .clk              (clk),
        .reset            (reset),
        .valid_ID_in      (valid_ID_in),
        .valid_EXE_in     (valid_EXE_in),
        .valid_MEM_in     (valid_MEM_in),
        .opcode_ID_in     (opcode_ID_in),
        .alu_op_EXE_in    (alu_op_EXE_in),
        .rsrc_EXE_in      (rsrc_EXE_in),
        .is_jmp_EXE_in    (is_jmp_EXE_in),
        .jmp_addr_EXE_in  (jmp_addr_EXE_in),
        .mem_rd_MEM_in    (mem_rd_MEM_in),
        .mem_wr_MEM_in    (mem_wr_MEM_in),
        .addr_MEM_in      (addr_MEM_in),
        .sp_MEM_in        (sp_MEM_in),
        .pc_ID_in         (pc_ID_in),
        .pc_EXE_in        (pc_EXE_in),
        .pc_MEM_in        (pc_MEM_in),
        .mask_in          (mask_in),
        .eret_in          (eret_in),
        .flush_ID_out     (flush_ID_out),
        .flush_EXE_out    (flush_EXE_out),
        .flush_MEM_out    (flush_MEM_out),
        .stall_fetch_out  (stall_fetch_out),
        .vector_valid_out (vector_valid_out),
        .vector_addr_out  (vector_addr_out),
        .epc_out          (epc_out),
        .cause_out        (cause_out),
        .in_handler_out   (in_handler_out),
        .halted_out       (halted_out),
        .exc_count_out    (exc_count_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.v_id = 1'b0; s.v_exe = 1'b0; s.v_mem = 1'b0;
        s.opcode = 4'd1; s.alu_op = 4'd0; s.rsrc = 16'd7;
        s.is_jmp = 1'b0; s.jmp_addr = 32'h0;
        s.rd = 1'b0; s.wr = 1'b0; s.addr_mem = 16'd0;
        s.sp = 32'd3000; s.pc_id = 32'h0; s.pc_exe = 32'h0; s.pc_mem = 32'h0;
        s.mask = 6'b0; s.eret = 1'b0;
        s.exp_cause = 3'd0; s.exp_epc = 32'h0; s.exp_flush = 3'b000;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        valid_ID_in = s.v_id;        valid_EXE_in = s.v_exe;     valid_MEM_in = s.v_mem;
        opcode_ID_in = s.opcode;     alu_op_EXE_in = s.alu_op;   rsrc_EXE_in = s.rsrc;
        is_jmp_EXE_in = s.is_jmp;    jmp_addr_EXE_in = s.jmp_addr;
        mem_rd_MEM_in = s.rd;        mem_wr_MEM_in = s.wr;       addr_MEM_in = s.addr_mem;
        sp_MEM_in = s.sp;            pc_ID_in = s.pc_id;         pc_EXE_in = s.pc_exe;
        pc_MEM_in = s.pc_mem;        mask_in = s.mask;           eret_in = s.eret;
    endtask

    task automatic pushExpect(input logic [2:0] cause, input logic [31:0] epc);
        exp_t e;
        e.cause = cause;
        e.epc   = epc;
        e.vec   = VEC_BASE + 32'(cause) * 32'(VEC_STRIDE);
        sb.push_back(e);
    endtask

    task automatic waitHandler(input string tag);
        int n = 0;
        while (!in_handler_out && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_handler"}, in_handler_out, 1'b1);
        checkOutput({tag, "_vec_pulse_len"}, vector_valid_out, 1'b0);
    endtask

    task automatic enterHandler(input stim_t s, input string tag);
        @(negedge clk);
        applyStimulus(s);
        pushExpect(s.exp_cause, s.exp_epc);
        #1;
        checkOutput({tag, "_flush"}, {flush_MEM_out, flush_EXE_out, flush_ID_out}, s.exp_flush);
        checkOutput({tag, "_stall"}, stall_fetch_out, 1'b1);
        @(negedge clk);
        applyStimulus(idleStim());
        if (exp_count < 255) exp_count++;
        checkOutput({tag, "_cause"}, cause_out, s.exp_cause);
        checkOutput({tag, "_epc"}, epc_out, s.exp_epc);
        checkOutput({tag, "_count"}, exc_count_out, exp_count);
        waitHandler(tag);
    endtask

    task automatic eretCycle(input string tag);
        eret_in = 1'b1;
        @(negedge clk);
        eret_in = 1'b0;
        checkOutput({tag, "_eret_idle"}, in_handler_out, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flushes"}, {flush_MEM_out, flush_EXE_out, flush_ID_out, stall_fetch_out}, 4'h0);
        checkOutput({tag, "_flags"}, {vector_valid_out, in_handler_out, halted_out}, 3'b000);
        checkOutput({tag, "_epc"}, epc_out, 32'h0);
        checkOutput({tag, "_cause"}, cause_out, 3'd0);
        checkOutput({tag, "_count"}, exc_count_out, 8'd0);
        checkOutput({tag, "_vaddr"}, vector_addr_out, 32'h0);
    endtask

    always @(negedge clk) begin
        if (vector_valid_out) begin
            if (sb.size() == 0) begin
                checkOutput("vec_unexpected", 1'b1, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("vec_addr", vector_addr_out, mon_e.vec);
                checkOutput("vec_cause", cause_out, mon_e.cause);
                checkOutput("vec_epc", epc_out, mon_e.epc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        stim_t tbl[$];

        reset = 1'b1;
        applyStimulus(idleStim());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkAllZero("reset");

        // Divide by zero in EXE with exact flush/vector timing.
        @(negedge clk);
        s = idleStim();
        s.v_exe = 1'b1; s.alu_op = 4'd10; s.rsrc = 16'd0; s.pc_exe = 32'h40;
        s.v_id = 1'b1; s.opcode = 4'd2; s.pc_id = 32'h44;
        applyStimulus(s);
        pushExpect(3'd4, 32'h40);
        #1;
        checkOutput("div0_flush", {flush_MEM_out, flush_EXE_out, flush_ID_out}, 3'b011);
        checkOutput("div0_stall", stall_fetch_out, 1'b1);
        @(negedge clk);
        applyStimulus(idleStim());
        exp_count = 1;
        checkOutput("div0_cause", cause_out, 3'd4);
        checkOutput("div0_epc", epc_out, 32'h40);
        checkOutput("div0_count", exc_count_out, 8'd1);
        checkOutput("div0_flush_all", {flush_MEM_out, flush_EXE_out, flush_ID_out, stall_fetch_out}, 4'hF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("div0_no_early_vec", vector_valid_out, 1'b0);
        end
        @(negedge clk);
        checkOutput("div0_vec_valid", vector_valid_out, 1'b1);
        checkOutput("div0_vec_addr", vector_addr_out, 32'h30);
        @(negedge clk);
        checkOutput("div0_in_handler", in_handler_out, 1'b1);
        checkOutput("div0_vec_once", vector_valid_out, 1'b0);
        checkOutput("div0_handler_noflush", {flush_MEM_out, flush_EXE_out, flush_ID_out, stall_fetch_out}, 4'h0);
        eretCycle("div0");
        checkOutput("div0_cause_hold", cause_out, 3'd4);

        // Simultaneous ID bad opcode and MEM SP overflow: MEM wins.
        s = idleStim();
        s.v_id = 1'b1; s.opcode = 4'd12; s.pc_id = 32'h108;
        s.v_mem = 1'b1; s.sp = 32'd4096; s.pc_mem = 32'h100;
        s.exp_cause = 3'd1; s.exp_epc = 32'h100; s.exp_flush = 3'b111;
        enterHandler(s, "same_cycle");
        eretCycle("same_cycle");

        // Masked div0 is ignored until unmasked.
        @(negedge clk);
        s = idleStim();
        s.v_exe = 1'b1; s.alu_op = 4'd10; s.rsrc = 16'd0; s.pc_exe = 32'h80;
        s.mask = 6'b001000;
        applyStimulus(s);
        #1;
        checkOutput("mask_flush", {flush_MEM_out, flush_EXE_out, flush_ID_out, stall_fetch_out}, 4'h0);
        @(negedge clk);
        checkOutput("mask_count", exc_count_out, exp_count);
        checkOutput("mask_not_flushing", {flush_MEM_out, flush_EXE_out, flush_ID_out}, 3'b000);
        s.mask = 6'b0;
        s.exp_cause = 3'd4; s.exp_epc = 32'h80; s.exp_flush = 3'b011;
        applyStimulus(s);
        pushExpect(3'd4, 32'h80);
        #1;
        checkOutput("unmask_flush", {flush_MEM_out, flush_EXE_out, flush_ID_out}, 3'b011);
        @(negedge clk);
        applyStimulus(idleStim());
        exp_count++;
        checkOutput("unmask_cause", cause_out, 3'd4);
        checkOutput("unmask_epc", epc_out, 32'h80);
        waitHandler("unmask");
        eretCycle("unmask");

        // Legal boundary values raise nothing.
        @(negedge clk);
        s = idleStim();
        s.v_id = 1'b1; s.opcode = 4'd10;
        s.v_exe = 1'b1; s.is_jmp = 1'b1; s.jmp_addr = 32'hFFFFF; s.alu_op = 4'd10; s.rsrc = 16'd1;
        s.v_mem = 1'b1; s.sp = 32'd4095; s.rd = 1'b1; s.addr_mem = 16'd4095;
        applyStimulus(s);
        #1;
        checkOutput("bound_hi_quiet", {flush_MEM_out, flush_EXE_out, flush_ID_out, stall_fetch_out}, 4'h0);
        s.sp = 32'd2047;
        applyStimulus(s);
        #1;
        checkOutput("bound_lo_quiet", stall_fetch_out, 1'b0);
        s = idleStim();
        s.v_exe = 1'b0; s.alu_op = 4'd10; s.rsrc = 16'd0;
        s.v_id = 1'b0; s.opcode = 4'd15;
        applyStimulus(s);
        #1;
        checkOutput("bubble_quiet", stall_fetch_out, 1'b0);

        // Priority table.
        s = idleStim();
        s.v_mem = 1'b1; s.sp = 32'd100; s.pc_mem = 32'h500;
        s.exp_cause = 3'd2; s.exp_epc = 32'h500; s.exp_flush = 3'b111;
        tbl.push_back(s);
        s = idleStim();
        s.v_mem = 1'b1; s.rd = 1'b1; s.addr_mem = 16'd5000; s.pc_mem = 32'h600;
        s.v_exe = 1'b1; s.alu_op = 4'd10; s.rsrc = 16'd0; s.pc_exe = 32'h604;
        s.exp_cause = 3'd6; s.exp_epc = 32'h600; s.exp_flush = 3'b111;
        tbl.push_back(s);
        s = idleStim();
        s.v_exe = 1'b1; s.is_jmp = 1'b1; s.jmp_addr = 32'h100000; s.pc_exe = 32'h700;
        s.v_id = 1'b1; s.opcode = 4'd11; s.pc_id = 32'h704;
        s.exp_cause = 3'd5; s.exp_epc = 32'h700; s.exp_flush = 3'b011;
        tbl.push_back(s);
        s = idleStim();
        s.v_mem = 1'b1; s.wr = 1'b1; s.addr_mem = 16'd4096; s.pc_mem = 32'h800;
        s.exp_cause = 3'd6; s.exp_epc = 32'h800; s.exp_flush = 3'b111;
        tbl.push_back(s);
        s = idleStim();
        s.v_id = 1'b1; s.opcode = 4'd11; s.pc_id = 32'h900;
        s.exp_cause = 3'd3; s.exp_epc = 32'h900; s.exp_flush = 3'b001;
        tbl.push_back(s);
        foreach (tbl[i]) begin
            enterHandler(tbl[i], $sformatf("prio%0d", i));
            eretCycle($sformatf("prio%0d", i));
        end

        // Double fault with simultaneous ERET: fault wins, core halts.
        s = idleStim();
        s.v_exe = 1'b1; s.is_jmp = 1'b1; s.jmp_addr = 32'h200000; s.pc_exe = 32'hA00;
        s.exp_cause = 3'd5; s.exp_epc = 32'hA00; s.exp_flush = 3'b011;
        enterHandler(s, "pre_double");
        s = idleStim();
        s.v_mem = 1'b1; s.rd = 1'b1; s.addr_mem = 16'd5000; s.pc_mem = 32'h300; s.eret = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        applyStimulus(idleStim());
        checkOutput("double_halted", halted_out, 1'b1);
        checkOutput("double_cause", cause_out, 3'd7);
        checkOutput("double_epc", epc_out, 32'h300);
        checkOutput("double_not_handler", in_handler_out, 1'b0);
        checkOutput("double_flush", {flush_MEM_out, flush_EXE_out, flush_ID_out, stall_fetch_out}, 4'hF);
        eret_in = 1'b1;
        repeat (2) @(negedge clk);
        eret_in = 1'b0;
        checkOutput("halt_sticky", halted_out, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        checkAllZero("halt_reset");

        // Reset in the middle of FLUSH: no vector afterwards.
        @(negedge clk);
        s = idleStim();
        s.v_id = 1'b1; s.opcode = 4'd13; s.pc_id = 32'hB00;
        applyStimulus(s);
        @(negedge clk);
        applyStimulus(idleStim());
        checkOutput("midflush_in_flush", stall_fetch_out, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midflush_reset");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("midflush_no_vec", {vector_valid_out, in_handler_out}, 2'b00);
        end

        // Counter saturation across 256 rounds.
        for (int i = 0; i < 256; i++) begin
            s = idleStim();
            s.v_id = 1'b1; s.opcode = 4'd15; s.pc_id = 32'(i * 4);
            s.exp_cause = 3'd3; s.exp_epc = 32'(i * 4); s.exp_flush = 3'b001;
            enterHandler(s, "sat");
            eretCycle("sat");
        end
        checkOutput("sat_final", exc_count_out, 8'd255);

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
